fifo_drain: RTL and testbench

- Read-side consumer for the 16-entry byte FIFO; it sits on the FIFO's ren/rdata/empty/count port.
- Gathers stored bytes into bursts of up to BURST words and presents them on a valid/ready stream with first/last framing.
- Never issues a read into an empty FIFO, so the FIFO's read-while-empty skip path is never exercised.
- Upstream writers may keep overfilling; overwrite semantics remain the FIFO's concern.

---
 rtl/fifo_drain.sv | 145 ++++++++++++++
 tb/tb_fifo_drain.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// Read-side consumer for the byte FIFO: gathers stored words into bursts of up to
// BURST words and presents them on a valid/ready stream with first/last framing.
module fifo_drain #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_ren,
  input  logic              flush,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_first,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
);

  localparam int unsigned REM_W = $clog2(BURST + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned LVL_W = CNT_W + 1;

  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST);
  localparam logic [REM_W-1:0] BURST_REM = REM_W'(BURST);
  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              first;
    logic              last;
  } entry_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [REM_W-1:0]  remaining;
  logic              first_pending;
  logic              inflight;
  logic              if_first;
  logic              if_last;
  entry_t            skid0;
  entry_t            skid1;
  logic [1:0]        occ;

  logic [LVL_W-1:0]  level;
  logic [1:0]        load;
  logic              pop;
  logic              space;
  logic              trigger;
  logic [REM_W-1:0]  burst_len;
  entry_t            new_entry;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = skid0.data;
  assign m_first   = skid0.first;
  assign m_last    = skid0.last;
  assign busy      = (state == ST_BURST) || (occ != 2'd0) || inflight;
  assign new_entry = '{data: fifo_rdata, first: if_first, last: if_last};

  // A full FIFO wraps its count to 0 while not empty; treat that as the top occupancy.
  always_comb begin
    level     = {(fifo_count == '0) && !fifo_empty, fifo_count};
    load      = occ + {1'b0, inflight};
    pop       = m_valid && m_ready;
    space     = (load < 2'd2) || ((load == 2'd2) && pop);
    trigger   = (level >= BURST_LVL) || ((timer == TMR_MAX) && (level != '0)) ||
                (flush && !fifo_empty);
    burst_len = (level >= BURST_LVL) ? BURST_REM : REM_W'(level);
    fifo_ren  = (state == ST_BURST) && !fifo_empty && (remaining != '0) && space;
  end

  // Burst control, read tagging and the 2-entry skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      timer         <= '0;
      remaining     <= '0;
      first_pending <= 1'b0;
      inflight      <= 1'b0;
      if_first      <= 1'b0;
      if_last       <= 1'b0;
      skid0         <= '0;
      skid1         <= '0;
      occ           <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state         <= ST_BURST;
            remaining     <= burst_len;
            timer         <= '0;
            first_pending <= 1'b1;
          end else if (level == '0) begin
            timer <= '0;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TMR_W'(1);
          end
        end
        ST_BURST: begin
          if (fifo_ren) begin
            remaining     <= remaining - REM_W'(1);
            first_pending <= 1'b0;
            if (remaining == REM_W'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      inflight <= fifo_ren;
      if (fifo_ren) begin
        if_first <= first_pending;
        if_last  <= (remaining == REM_W'(1));
      end

      // Oldest entry always sits in skid0.
      case ({inflight, pop})
        2'b01: begin
          skid0 <= skid1;
          occ   <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) skid0 <= new_entry;
          else             skid1 <= new_entry;
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            skid0 <= new_entry;
          end else begin
            skid0 <= skid1;
            skid1 <= new_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: drives a 16-entry overwrite FIFO model and
// checks burst framing, timing, back-pressure and reset behaviour.
module tb_fifo_drain;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic [3:0] fifo_count;
  logic [7:0] fifo_rdata;
  logic       fifo_ren;
  logic       flush;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_first;
  logic       m_last;
  logic       m_ready;
  logic       busy;

  logic       wr_en;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_drain dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_first    (m_first),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-entry FIFO with overwrite-oldest on write while full; count wraps to 0 when full.
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;
  int         cnt = 0;
  logic       fifo_rd;

  assign fifo_count = 4'(cnt);
  assign fifo_empty = (cnt == 0);
  assign fifo_rd    = fifo_ren && (cnt != 0);

  initial fifo_rdata = 8'h00;

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_rdata <= mem[rp];
      rp         <= rp + 4'd1;
    end
    if (wr_en) begin
      mem[wp] <= wr_data;
      wp      <= wp + 4'd1;
      if (cnt == 16 && !fifo_rd) rp <= rp + 4'd1;
    end
    if (wr_en && !fifo_rd && cnt < 16) cnt <= cnt + 1;
    else if (fifo_rd && !wr_en)        cnt <= cnt - 1;
  end

  // Observation log, sampled on the falling edge.
  int         cyc = 0;
  int         ren_viol = 0;
  int         stab_viol = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_first = 1'b0;
  logic       prev_last = 1'b0;
  int         ren_cyc [$];
  logic [7:0] w_data [$];
  logic       w_first [$];
  logic       w_last [$];
  int         w_cyc [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (fifo_ren) ren_cyc.push_back(cyc);
      if (fifo_ren && fifo_empty) ren_viol <= ren_viol + 1;
      if (stall_prev && (m_valid !== 1'b1 || m_data !== prev_data ||
                         m_first !== prev_first || m_last !== prev_last))
        stab_viol <= stab_viol + 1;
      if (m_valid && m_ready) begin
        w_data.push_back(m_data);
        w_first.push_back(m_first);
        w_last.push_back(m_last);
        w_cyc.push_back(cyc);
      end
    end
    stall_prev <= rst_n && m_valid && !m_ready;
    prev_data  <= m_data;
    prev_first <= m_first;
    prev_last  <= m_last;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic clear_log();
    ren_cyc.delete();
    w_data.delete();
    w_first.delete();
    w_last.delete();
    w_cyc.delete();
  endtask

  task automatic write_bytes(input logic [7:0] b [8], input int n,
                             output int t_first, output int t_last);
    t_first = 0;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = b[i];
      @(posedge clk); #1;
      if (i == 0) t_first = cyc;
    end
    wr_en  = 1'b0;
    t_last = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy && fifo_empty && !fifo_ren) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (fifo_ren !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_ren: got %b want 0", fifo_ren); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", m_data); end
    n_checks++; if (m_first !== 1'b0) begin n_fail++; $display("FAIL reset_m_first: got %b want 0", m_first); end
    n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (m_valid !== 1'b0 || busy !== 1'b0 || fifo_ren !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: valid=%b busy=%b ren=%b want 0 0 0", m_valid, busy, fifo_ren);
    end
  endtask

  task automatic test_full_burst();
    logic [7:0] b [8];
    int t0, t1;
    bit ok;
    b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    m_ready = 1'b1;
    write_bytes(b, 4, t0, t1);
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_idle: got %b want 1", ok); end
    n_checks++; if (ren_cyc.size() !== 4) begin n_fail++; $display("FAIL full_ren_count: got %0d want 4", ren_cyc.size()); end
    for (int i = 0; i < 4 && i < ren_cyc.size(); i++) begin
      n_checks++; if (ren_cyc[i] !== t1 + 1 + i) begin n_fail++; $display("FAIL full_ren_cycle[%0d]: got %0d want %0d", i, ren_cyc[i], t1 + 1 + i); end
    end
    n_checks++; if (w_data.size() !== 4) begin n_fail++; $display("FAIL full_word_count: got %0d want 4", w_data.size()); end
    for (int i = 0; i < 4 && i < w_data.size(); i++) begin
      n_checks++; if (w_data[i] !== 8'(8'h11 + i) || w_first[i] !== (i == 0) || w_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL full_word[%0d]: got %h f=%b l=%b want %h f=%b l=%b", i, w_data[i], w_first[i], w_last[i], 8'(8'h11 + i), (i == 0), (i == 3));
      end
      n_checks++; if (w_cyc[i] !== t1 + 3 + i) begin n_fail++; $display("FAIL full_word_cycle[%0d]: got %0d want %0d", i, w_cyc[i], t1 + 3 + i); end
    end
    n_checks++; if (fifo_count !== 4'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: count=%0d empty=%b want 0 1", fifo_count, fifo_empty); end
  endtask

  task automatic test_timeout();
    logic [7:0] b [8];
    int t0, t1;
    bit ok;
    b = '{8'hA0, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    m_ready = 1'b1;
    write_bytes(b, 2, t0, t1);
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: got %b want 1", ok); end
    n_checks++; if (ren_cyc.size() !== 2) begin n_fail++; $display("FAIL timeout_ren_count: got %0d want 2", ren_cyc.size()); end
    if (ren_cyc.size() > 0) begin
      n_checks++; if (ren_cyc[0] !== t0 + 13) begin n_fail++; $display("FAIL timeout_first_ren: got %0d want %0d", ren_cyc[0], t0 + 13); end
    end
    n_checks++; if (w_data.size() !== 2) begin n_fail++; $display("FAIL timeout_word_count: got %0d want 2", w_data.size()); end
    if (w_data.size() == 2) begin
      n_checks++; if (w_data[0] !== 8'hA0 || w_first[0] !== 1'b1 || w_last[0] !== 1'b0) begin
        n_fail++; $display("FAIL timeout_word0: got %h f=%b l=%b want a0 f=1 l=0", w_data[0], w_first[0], w_last[0]);
      end
      n_checks++; if (w_data[1] !== 8'hA1 || w_first[1] !== 1'b0 || w_last[1] !== 1'b1) begin
        n_fail++; $display("FAIL timeout_word1: got %h f=%b l=%b want a1 f=0 l=1", w_data[1], w_first[1], w_last[1]);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int sv, rv;
    bit ok;
    clear_log();
    sv = stab_viol;
    rv = ren_viol;
    for (int i = 0; i < 60; i++) begin
      m_ready = (i % 2 == 1);
      wr_en   = (i < 8);
      wr_data = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b want 1", ok); end
    n_checks++; if (w_data.size() !== 8) begin n_fail++; $display("FAIL bp_word_count: got %0d want 8", w_data.size()); end
    for (int i = 0; i < 8 && i < w_data.size(); i++) begin
      n_checks++; if (w_data[i] !== 8'(8'h30 + i) || w_first[i] !== (i % 4 == 0) || w_last[i] !== (i % 4 == 3)) begin
        n_fail++; $display("FAIL bp_word[%0d]: got %h f=%b l=%b want %h f=%b l=%b", i, w_data[i], w_first[i], w_last[i], 8'(8'h30 + i), (i % 4 == 0), (i % 4 == 3));
      end
    end
    n_checks++; if (stab_viol - sv !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes want 0", stab_viol - sv); end
    n_checks++; if (ren_viol - rv !== 0) begin n_fail++; $display("FAIL bp_ren_empty: got %0d want 0", ren_viol - rv); end
    n_checks++; if (ren_cyc.size() !== 8) begin n_fail++; $display("FAIL bp_ren_count: got %0d want 8", ren_cyc.size()); end
  endtask

  task automatic test_flush();
    logic [7:0] b [8];
    int t0, t1;
    bit ok;
    b = '{8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    m_ready = 1'b1;
    write_bytes(b, 1, t0, t1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle(50, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %b want 1", ok); end
    n_checks++; if (ren_cyc.size() !== 1) begin n_fail++; $display("FAIL flush_ren_count: got %0d want 1", ren_cyc.size()); end
    if (ren_cyc.size() > 0) begin
      n_checks++; if (ren_cyc[0] !== t1 + 1) begin n_fail++; $display("FAIL flush_ren_cycle: got %0d want %0d", ren_cyc[0], t1 + 1); end
    end
    n_checks++; if (w_data.size() !== 1) begin n_fail++; $display("FAIL flush_word_count: got %0d want 1", w_data.size()); end
    if (w_data.size() > 0) begin
      n_checks++; if (w_data[0] !== 8'h5C || w_first[0] !== 1'b1 || w_last[0] !== 1'b1) begin
        n_fail++; $display("FAIL flush_word: got %h f=%b l=%b want 5c f=1 l=1", w_data[0], w_first[0], w_last[0]);
      end
    end
    clear_log();
    flush = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b0;
    n_checks++; if (ren_cyc.size() !== 0) begin n_fail++; $display("FAIL flush_empty_ren: got %0d reads want 0", ren_cyc.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_empty_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] b [8];
    int t0, t1;
    bit ok;
    b = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    m_ready = 1'b1;
    write_bytes(b, 4, t0, t1);
    for (int i = 0; i < 20; i++) begin
      if (ren_cyc.size() >= 2) break;
      @(posedge clk); #1;
    end
    n_checks++; if (ren_cyc.size() !== 2) begin n_fail++; $display("FAIL rst_mid_reads: got %0d want 2", ren_cyc.size()); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || m_data !== 8'h00 ||
                    m_first !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: ren=%b valid=%b data=%h first=%b last=%b busy=%b want all 0",
                         fifo_ren, m_valid, m_data, m_first, m_last, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_release: ren=%b valid=%b busy=%b want 0 0 0", fifo_ren, m_valid, busy);
    end
    wait_idle(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 1", ok); end
    n_checks++; if (w_data.size() !== 2) begin n_fail++; $display("FAIL rst_mid_word_count: got %0d want 2", w_data.size()); end
    if (w_data.size() == 2) begin
      n_checks++; if (w_data[0] !== 8'h23 || w_first[0] !== 1'b1 || w_last[0] !== 1'b0 ||
                      w_data[1] !== 8'h24 || w_first[1] !== 1'b0 || w_last[1] !== 1'b1) begin
        n_fail++; $display("FAIL rst_mid_words: got %h/%b%b %h/%b%b want 23/10 24/01",
                           w_data[0], w_first[0], w_last[0], w_data[1], w_first[1], w_last[1]);
      end
    end
  endtask

  task automatic test_random();
    int sv, rv, ferr, oerr, nf, nl, flen;
    bit in_frame, ok;
    logic [7:0] seq;
    clear_log();
    sv = stab_viol; rv = ren_viol;
    ferr = 0; oerr = 0; nf = 0; nl = 0; flen = 0; in_frame = 1'b0;
    seq = 8'h00;
    for (int i = 0; i < 250; i++) begin
      wr_en   = ($urandom_range(0, 3) != 0);
      wr_data = seq;
      if (wr_en) seq = seq + 8'd1;
      m_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    wait_idle(300, ok);
    for (int i = 0; i < w_data.size(); i++) begin
      if (w_first[i]) begin
        nf++;
        if (in_frame) ferr++;
        in_frame = 1'b1;
        flen = 0;
      end
      if (!in_frame) ferr++;
      flen++;
      if (flen > 4) ferr++;
      if (w_last[i]) begin
        nl++;
        in_frame = 1'b0;
      end
      if (i > 0 && w_data[i] <= w_data[i-1]) oerr++;
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rand_idle: got %b want 1", ok); end
    n_checks++; if (ren_viol - rv !== 0) begin n_fail++; $display("FAIL rand_ren_empty: got %0d want 0", ren_viol - rv); end
    n_checks++; if (stab_viol - sv !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d want 0", stab_viol - sv); end
    n_checks++; if (ferr !== 0) begin n_fail++; $display("FAIL rand_framing: got %0d errors want 0", ferr); end
    n_checks++; if (oerr !== 0) begin n_fail++; $display("FAIL rand_order: got %0d errors want 0", oerr); end
    n_checks++; if (nf !== nl) begin n_fail++; $display("FAIL rand_first_last: got %0d firsts %0d lasts want equal", nf, nl); end
    n_checks++; if (nf == 0) begin n_fail++; $display("FAIL rand_bursts: got 0 bursts want nonzero"); end
    n_checks++; if (in_frame !== 1'b0) begin n_fail++; $display("FAIL rand_open_frame: got %b want 0", in_frame); end
  endtask

  initial begin
    test_reset();
    test_full_burst();
    test_timeout();
    test_backpressure();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
